// File: rtl/instr_encoder.sv
// Packs decoded RV fields plus a wide signed immediate into a 32-bit instruction,
// range-checks the immediate, and streams the result with its byte address.
module instr_encoder #(
  parameter int          WORDSIZE         = 64,
  parameter int          INSTRUCTION_SIZE = 32,
  parameter int          ADDR_WIDTH       = 12,
  parameter int unsigned BASE_ADDR        = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  fmt,
  input  logic [6:0]                  opcode,
  input  logic [4:0]                  rd,
  input  logic [4:0]                  rs1,
  input  logic [4:0]                  rs2,
  input  logic [2:0]                  funct3,
  input  logic [6:0]                  funct7,
  input  logic [WORDSIZE-1:0]         immediate,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic                        out_err,
  output logic [7:0]                  err_count
);

  localparam logic [31:0]           NOP       = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] ADDR_RST  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

  // True when imm[WORDSIZE-1:lsb] is a pure sign extension.
  function automatic logic fits_signed(input logic [WORDSIZE-1:0] imm, input int lsb);
    logic signed [WORDSIZE-1:0] s;
    logic signed [WORDSIZE-1:0] hi;
    s  = imm;
    hi = s >>> lsb;
    return (hi == '0) || (hi == '1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Returns {err, instruction}; errored encodings collapse to a NOP.
  function automatic logic [32:0] encode(
    input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
    input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
    input logic [6:0] f7, input logic [WORDSIZE-1:0] imm);
    logic [31:0] ins;
    logic        err;
    ins = NOP;
    err = 1'b0;
    case (f)
      3'd0: ins = {f7, s2, s1, f3, d, op};
      3'd1: begin
        ins = {imm[11:0], s1, f3, d, op};
        err = !fits_signed(imm, 11);
      end
      3'd2: begin
        ins = {imm[11:5], s2, s1, f3, imm[4:0], op};
        err = !fits_signed(imm, 11);
      end
      3'd3: begin
        ins = {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], op};
        err = !fits_signed(imm, 12) || imm[0];
      end
      3'd4: begin
        ins = {imm[31:12], d, op};
        err = !fits_signed(imm, 31) || (imm[11:0] != 12'd0);
      end
      3'd5: begin
        ins = {imm[20], imm[10:1], imm[11], imm[19:12], d, op};
        err = !fits_signed(imm, 20) || imm[0];
      end
      default: err = 1'b1;
    endcase
    if (err) ins = NOP;
    return {err, ins};
  endfunction

  logic [32:0]           enc_p0;
  logic                  accept_p0;
  logic                  xfer_p1;
  logic                  vld_p1;
  logic [31:0]           instr_p1;
  logic                  err_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [7:0]            err_cnt;

  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;
  assign xfer_p1   = vld_p1 && out_ready;
  assign enc_p0    = encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, immediate);

  // p0 -> p1: output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      err_p1   <= 1'b0;
      addr_p1  <= ADDR_RST;
      addr_cnt <= ADDR_RST;
      err_cnt  <= '0;
    end else begin
      if (accept_p0) begin
        vld_p1   <= 1'b1;
        instr_p1 <= enc_p0[31:0];
        err_p1   <= enc_p0[32];
        addr_p1  <= addr_cnt;
        addr_cnt <= addr_cnt + ADDR_STEP;
      end else if (xfer_p1) begin
        vld_p1 <= 1'b0;
      end
      if (xfer_p1 && err_p1) err_cnt <= sat_inc(err_cnt);
    end
  end

  assign out_valid   = vld_p1;
  assign instruction = INSTRUCTION_SIZE'(instr_p1);
  assign out_addr    = addr_p1;
  assign out_err     = err_p1;
  assign err_count   = err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, range errors, backpressure,
// address wrap (second instance with ADDR_WIDTH=4), err_count saturation, reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [63:0] immediate = '0;

  logic        in_ready, out_valid, out_err;
  logic [31:0] instruction;
  logic [11:0] out_addr;
  logic [7:0]  err_count;

  logic        w_in_ready, w_out_valid, w_out_err;
  logic [31:0] w_instruction;
  logic [3:0]  w_out_addr;
  logic [7:0]  w_err_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  instr_encoder #(.ADDR_WIDTH(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .immediate(immediate),
    .out_valid(w_out_valid), .out_ready(out_ready), .instruction(w_instruction),
    .out_addr(w_out_addr), .out_err(w_out_err), .err_count(w_err_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [63:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; immediate = im;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [63:0] im);
    load(f, op, d, s1, s2, f3, f7, im);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] ins,
                            input logic [11:0] addr, input logic err);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_instr"}, instruction, ins);
    chk({tag, "_addr"}, out_addr, addr);
    chk({tag, "_err"}, out_err, err);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_err", out_err, 1'b0);
    chk("rst_errcnt", err_count, 8'd0);
    chk("rst_addr", out_addr, 12'h000);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    tick();

    // Encodings, back to back with out_ready high
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5);
    expect_out("addi", 32'h0050_0093, 12'h000, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd8);
    expect_out("beq", 32'h0020_8463, 12'h004, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd16);
    expect_out("jal", 32'h0100_00EF, 12'h008, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000);
    expect_out("lui", 32'h1234_52B7, 12'h00C, 1'b0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
    expect_out("i_range", 32'h0000_0013, 12'h010, 1'b1);
    chk("errcnt_pre", err_count, 8'd0);
    tick();
    chk("errcnt_xfer_valid", out_valid, 1'b0);
    chk("errcnt_xfer", err_count, 8'd1);

    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd6);
    expect_out("b_even", 32'h0020_8363, 12'h014, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd7);
    expect_out("b_odd", 32'h0000_0013, 12'h018, 1'b1);
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    expect_out("fmt6", 32'h0000_0013, 12'h01C, 1'b1);
    chk("errcnt_b", err_count, 8'd2);
    send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_out("r_sub", 32'h4031_00B3, 12'h020, 1'b0);
    chk("errcnt_fmt6", err_count, 8'd3);
    send(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC);
    expect_out("s_neg", 32'hFE51_2E23, 12'h024, 1'b0);

    // Reset while an errored result is pending
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    expect_out("fmt7", 32'h0000_0013, 12'h028, 1'b1);
    out_ready = 1'b0;
    tick();
    chk("pend_valid", out_valid, 1'b1);
    chk("pend_errcnt", err_count, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_errcnt", err_count, 8'd0);
    chk("mid_rst_addr", out_addr, 12'h000);
    chk("mid_rst_instr", instruction, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Backpressure then back-to-back stream, with address wrap on the 4-bit instance
    load(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5);
    tick();
    expect_out("bp_first", 32'h0050_0093, 12'h000, 1'b0);
    chk("wrap_a0", w_out_addr, 4'h0);
    load(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 1'b0);
      tick();
      expect_out("bp_hold", 32'h0050_0093, 12'h000, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    tick();
    expect_out("st1", 32'h1234_52B7, 12'h004, 1'b0);
    chk("wrap_a1", w_out_addr, 4'h4);
    load(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd16);
    tick();
    expect_out("st2", 32'h0100_00EF, 12'h008, 1'b0);
    chk("wrap_a2", w_out_addr, 4'h8);
    load(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd8);
    tick();
    expect_out("st3", 32'h0020_8463, 12'h00C, 1'b0);
    chk("wrap_a3", w_out_addr, 4'hC);
    load(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5);
    tick();
    expect_out("st4", 32'h0050_0093, 12'h010, 1'b0);
    chk("wrap_a4", w_out_addr, 4'h0);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 1'b0);

    // err_count saturation: 300 errored transfers
    load(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_mid", err_count, 8'd9);
    for (int i = 0; i < 290; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("sat_valid", out_valid, 1'b0);
    chk("sat_errcnt", err_count, 8'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
